// File: rtl/instr_compressor.sv
// Compresses 32-bit instructions into 16-bit dictionary key codewords.
// Three append-only field dictionaries are searched in parallel, one index per cycle.
module instr_compressor #(
    parameter int FIELD1_KEY_WIDTH = 3,
    parameter int FIELD2_KEY_WIDTH = 5,
    parameter int FIELD3_KEY_WIDTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        dict1_write_enable,
    input  logic        dict2_write_enable,
    input  logic        dict3_write_enable,
    input  logic [6:0]  dict1_write_val,
    input  logic [9:0]  dict2_write_val,
    input  logic [14:0] dict3_write_val,
    input  logic        dict_clear,
    output logic [2:0]  dict_full,
    output logic        dict_drop,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_compressible,
    output logic [15:0] out_code,
    output logic [31:0] out_instr,
    output logic [31:0] stat_total,
    output logic [31:0] stat_hits
);
    localparam int K1 = FIELD1_KEY_WIDTH;
    localparam int K2 = FIELD2_KEY_WIDTH;
    localparam int K3 = FIELD3_KEY_WIDTH;
    localparam int DEPTH1 = 2 ** K1;
    localparam int DEPTH2 = 2 ** K2;
    localparam int DEPTH3 = 2 ** K3;
    localparam int IDX_W = (K3 > K2) ? ((K3 > K1) ? K3 : K1) : ((K2 > K1) ? K2 : K1);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
        return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    logic [6:0]  dict1_mem [DEPTH1];
    logic [9:0]  dict2_mem [DEPTH2];
    logic [14:0] dict3_mem [DEPTH3];
    logic [K1:0] cnt1_q, cnt1_d;
    logic [K2:0] cnt2_q, cnt2_d;
    logic [K3:0] cnt3_q, cnt3_d;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic        found1_q, found1_d, found2_q, found2_d, found3_q, found3_d;
    logic [K1-1:0] key1_q, key1_d;
    logic [K2-1:0] key2_q, key2_d;
    logic [K3-1:0] key3_q, key3_d;
    logic        out_valid_q, out_valid_d, out_comp_q, out_comp_d;
    logic [15:0] out_code_q, out_code_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] stat_total_q, stat_total_d, stat_hits_q, stat_hits_d;
    logic        drop_q, drop_d;

    logic        full1, full2, full3, wr_allow, wr1_ok, wr2_ok, wr3_ok;
    logic [6:0]  f1;
    logic [9:0]  f2;
    logic [14:0] f3;
    logic        hit1, hit2, hit3, ex1, ex2, ex3;

    assign full1 = (32'(cnt1_q) == DEPTH1);
    assign full2 = (32'(cnt2_q) == DEPTH2);
    assign full3 = (32'(cnt3_q) == DEPTH3);
    // The async reset forces IDLE, so this also admits loading while resetn is low.
    assign wr_allow = (state_q == IDLE);
    assign wr1_ok = dict1_write_enable && wr_allow && !full1 && !dict_clear;
    assign wr2_ok = dict2_write_enable && wr_allow && !full2 && !dict_clear;
    assign wr3_ok = dict3_write_enable && wr_allow && !full3 && !dict_clear;

    always_comb begin
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        cnt3_d = cnt3_q;
        if (dict_clear) begin
            cnt1_d = '0;
            cnt2_d = '0;
            cnt3_d = '0;
        end else begin
            if (wr1_ok) cnt1_d = cnt1_q + 1'b1;
            if (wr2_ok) cnt2_d = cnt2_q + 1'b1;
            if (wr3_ok) cnt3_d = cnt3_q + 1'b1;
        end
        drop_d = !dict_clear && ((dict1_write_enable && !wr1_ok) ||
                                 (dict2_write_enable && !wr2_ok) ||
                                 (dict3_write_enable && !wr3_ok));
    end

    // Dictionary contents and pointers deliberately survive resetn.
    always_ff @(posedge clk) begin
        if (wr1_ok) dict1_mem[cnt1_q[K1-1:0]] <= dict1_write_val;
        if (wr2_ok) dict2_mem[cnt2_q[K2-1:0]] <= dict2_write_val;
        if (wr3_ok) dict3_mem[cnt3_q[K3-1:0]] <= dict3_write_val;
        cnt1_q <= cnt1_d;
        cnt2_q <= cnt2_d;
        cnt3_q <= cnt3_d;
    end

    assign f1 = instr_q[6:0];
    assign f2 = {instr_q[31:25], instr_q[14:12]};
    assign f3 = {instr_q[24:20], instr_q[19:15], instr_q[11:7]};

    assign hit1 = !found1_q && (32'(idx_q) < 32'(cnt1_q)) && (dict1_mem[idx_q[K1-1:0]] == f1);
    assign hit2 = !found2_q && (32'(idx_q) < 32'(cnt2_q)) && (dict2_mem[idx_q[K2-1:0]] == f2);
    assign hit3 = !found3_q && (32'(idx_q) < 32'(cnt3_q)) && (dict3_mem[idx_q[K3-1:0]] == f3);
    assign ex1 = (32'(idx_q) + 32'd1 >= 32'(cnt1_q));
    assign ex2 = (32'(idx_q) + 32'd1 >= 32'(cnt2_q));
    assign ex3 = (32'(idx_q) + 32'd1 >= 32'(cnt3_q));

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        idx_d        = idx_q;
        found1_d     = found1_q;
        found2_d     = found2_q;
        found3_d     = found3_q;
        key1_d       = key1_q;
        key2_d       = key2_q;
        key3_d       = key3_q;
        out_valid_d  = out_valid_q;
        out_comp_d   = out_comp_q;
        out_code_d   = out_code_q;
        out_instr_d  = out_instr_q;
        stat_total_d = stat_total_q;
        stat_hits_d  = stat_hits_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    instr_d  = in_instr;
                    idx_d    = '0;
                    found1_d = 1'b0;
                    found2_d = 1'b0;
                    found3_d = 1'b0;
                    state_d  = SEARCH;
                end
            end
            SEARCH: begin
                found1_d = found1_q | hit1;
                found2_d = found2_q | hit2;
                found3_d = found3_q | hit3;
                if (hit1) key1_d = idx_q[K1-1:0];
                if (hit2) key2_d = idx_q[K2-1:0];
                if (hit3) key3_d = idx_q[K3-1:0];
                if ((found1_d || ex1) && (found2_d || ex2) && (found3_d || ex3)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_comp_d  = found1_d && found2_d && found3_d;
                    out_code_d  = out_comp_d ? {key3_d, key2_d, key1_d} : 16'h0000;
                    out_instr_d = instr_q;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d      = IDLE;
                    out_valid_d  = 1'b0;
                    stat_total_d = sat_inc(stat_total_q, 1'b1);
                    stat_hits_d  = sat_inc(stat_hits_q, out_comp_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_comp_q   <= 1'b0;
            out_code_q   <= 16'h0000;
            out_instr_q  <= 32'h0;
            stat_total_q <= 32'h0;
            stat_hits_q  <= 32'h0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_comp_q   <= out_comp_d;
            out_code_q   <= out_code_d;
            out_instr_q  <= out_instr_d;
            stat_total_q <= stat_total_d;
            stat_hits_q  <= stat_hits_d;
            drop_q       <= drop_d;
        end
    end

    // Search working state is always initialised on accept, so it needs no reset.
    always_ff @(posedge clk) begin
        instr_q  <= instr_d;
        idx_q    <= idx_d;
        found1_q <= found1_d;
        found2_q <= found2_d;
        found3_q <= found3_d;
        key1_q   <= key1_d;
        key2_q   <= key2_d;
        key3_q   <= key3_d;
    end

    assign in_ready         = (state_q == IDLE) && resetn;
    assign dict_full        = {full3, full2, full1};
    assign dict_drop        = drop_q;
    assign out_valid        = out_valid_q;
    assign out_compressible = out_comp_q;
    assign out_code         = out_code_q;
    assign out_instr        = out_instr_q;
    assign stat_total       = stat_total_q;
    assign stat_hits        = stat_hits_q;
endmodule

// File: tb/tb_instr_compressor.sv
// Directed bench for instr_compressor: exact hits, offset hits, full-dictionary miss,
// output back-pressure, write drops and reset abort with dictionary retention.
module tb_instr_compressor;
    logic        clk = 1'b0;
    logic        resetn;
    logic        dict1_write_enable, dict2_write_enable, dict3_write_enable;
    logic [6:0]  dict1_write_val;
    logic [9:0]  dict2_write_val;
    logic [14:0] dict3_write_val;
    logic        dict_clear;
    logic [2:0]  dict_full;
    logic        dict_drop;
    logic        in_valid, in_ready;
    logic [31:0] in_instr;
    logic        out_valid, out_ready, out_compressible;
    logic [15:0] out_code;
    logic [31:0] out_instr, stat_total, stat_hits;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_compressor dut (
        .clk(clk), .resetn(resetn),
        .dict1_write_enable(dict1_write_enable), .dict2_write_enable(dict2_write_enable),
        .dict3_write_enable(dict3_write_enable),
        .dict1_write_val(dict1_write_val), .dict2_write_val(dict2_write_val),
        .dict3_write_val(dict3_write_val),
        .dict_clear(dict_clear), .dict_full(dict_full), .dict_drop(dict_drop),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_compressible(out_compressible),
        .out_code(out_code), .out_instr(out_instr),
        .stat_total(stat_total), .stat_hits(stat_hits)
    );

    task automatic wr(input int n, input logic [14:0] v);
        @(negedge clk);
        case (n)
            1: begin dict1_write_enable = 1'b1; dict1_write_val = v[6:0]; end
            2: begin dict2_write_enable = 1'b1; dict2_write_val = v[9:0]; end
            default: begin dict3_write_enable = 1'b1; dict3_write_val = v; end
        endcase
        @(negedge clk);
        dict1_write_enable = 1'b0;
        dict2_write_enable = 1'b0;
        dict3_write_enable = 1'b0;
    endtask

    task automatic clear_dicts();
        @(negedge clk);
        dict_clear = 1'b1;
        @(negedge clk);
        dict_clear = 1'b0;
    endtask

    // lat = k such that out_valid first appears after edge E(k); 300 means timeout.
    task automatic run(input logic [31:0] instr, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = instr;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic load_t1();
        clear_dicts();
        wr(1, 15'h13);
        wr(2, 15'h000);
        wr(3, 15'h0401);
    endtask

    task automatic load_t3();
        clear_dicts();
        wr(1, 15'h13);
        wr(2, 15'h000);
        for (int i = 0; i < 256; i++) wr(3, 15'h7FFF);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_compressible !== 1'b0 || out_code !== 16'h0 ||
            out_instr !== 32'h0 || dict_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b comp=%b code=%h instr=%h drop=%b, want all 0",
                     out_valid, out_compressible, out_code, out_instr, dict_drop);
        end
        checks++;
        if (stat_total !== 32'h0 || stat_hits !== 32'h0) begin
            errors++;
            $display("FAIL reset_stats: total=%0d hits=%0d, want 0 0", stat_total, stat_hits);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        clear_dicts();
        checks++;
        if (dict_full !== 3'b000) begin
            errors++;
            $display("FAIL reset_clear_full: got %b want 000", dict_full);
        end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_exact_hit_hold();
        int lat;
        logic stable;
        load_t1();
        run(32'h00100093, lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL t1_latency: got %0d want 1", lat);
        end
        checks++;
        if (out_compressible !== 1'b1 || out_code !== 16'h0000 || out_instr !== 32'h00100093) begin
            errors++;
            $display("FAIL t1_result: comp=%b code=%h instr=%h, want 1 0000 00100093",
                     out_compressible, out_code, out_instr);
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                in_valid = 1'b1;
                in_instr = 32'hDEADBEEF;
            end
            if (out_valid !== 1'b1 || out_compressible !== 1'b1 || out_code !== 16'h0000 ||
                out_instr !== 32'h00100093 || in_ready !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL t4_hold_stable: outputs changed or in_ready rose, got stable=%b want 1", stable);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || stat_total !== 32'd1 || stat_hits !== 32'd1) begin
            errors++;
            $display("FAIL t4_handshake: valid=%b total=%0d hits=%0d, want 0 1 1",
                     out_valid, stat_total, stat_hits);
        end
        checks++;
        if (in_ready !== 1'b1 || out_instr !== 32'h00100093) begin
            errors++;
            $display("FAIL t4_no_second_accept: in_ready=%b instr=%h, want 1 00100093",
                     in_ready, out_instr);
        end
    endtask

    task automatic test_offset_hit();
        int lat;
        clear_dicts();
        wr(1, 15'h7F); wr(1, 15'h7F); wr(1, 15'h13);
        for (int i = 0; i < 3; i++) wr(2, 15'h3FF);
        wr(2, 15'h000);
        for (int i = 0; i < 5; i++) wr(3, 15'h7FFF);
        wr(3, 15'h0401);
        run(32'h00100093, lat);
        checks++;
        if (lat != 6) begin
            errors++;
            $display("FAIL t2_latency: got %0d want 6", lat);
        end
        checks++;
        if (out_compressible !== 1'b1 || out_code !== 16'h051A) begin
            errors++;
            $display("FAIL t2_code: comp=%b code=%h, want 1 051a", out_compressible, out_code);
        end
        pop();
        checks++;
        if (stat_total !== 32'd2 || stat_hits !== 32'd2) begin
            errors++;
            $display("FAIL t2_stats: total=%0d hits=%0d, want 2 2", stat_total, stat_hits);
        end
    endtask

    task automatic test_full_miss();
        int lat;
        load_t3();
        checks++;
        if (dict_full !== 3'b100) begin
            errors++;
            $display("FAIL t3_full_flags: got %b want 100", dict_full);
        end
        run(32'h00100093, lat);
        checks++;
        if (lat != 256) begin
            errors++;
            $display("FAIL t3_latency: got %0d want 256", lat);
        end
        checks++;
        if (out_compressible !== 1'b0 || out_code !== 16'h0 || out_instr !== 32'h00100093) begin
            errors++;
            $display("FAIL t3_result: comp=%b code=%h instr=%h, want 0 0000 00100093",
                     out_compressible, out_code, out_instr);
        end
        pop();
        checks++;
        if (stat_total !== 32'd3 || stat_hits !== 32'd2) begin
            errors++;
            $display("FAIL t3_stats: total=%0d hits=%0d, want 3 2", stat_total, stat_hits);
        end
    endtask

    task automatic test_drop_and_clear();
        int lat;
        clear_dicts();
        for (int i = 0; i < 8; i++) wr(1, 15'(i + 1));
        checks++;
        if (dict_full !== 3'b001 || dict_drop !== 1'b0) begin
            errors++;
            $display("FAIL t5_eight_writes: full=%b drop=%b, want 001 0", dict_full, dict_drop);
        end
        wr(1, 15'h13);
        checks++;
        if (dict_drop !== 1'b1) begin
            errors++;
            $display("FAIL t5_ninth_drop: got %b want 1", dict_drop);
        end
        @(negedge clk);
        checks++;
        if (dict_drop !== 1'b0 || dict_full !== 3'b001) begin
            errors++;
            $display("FAIL t5_drop_pulse: drop=%b full=%b, want 0 001", dict_drop, dict_full);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = 32'h00100093;
        @(negedge clk);
        in_valid = 1'b0;
        dict2_write_enable = 1'b1;
        dict2_write_val = 10'h000;
        @(negedge clk);
        dict2_write_enable = 1'b0;
        lat = 1;
        checks++;
        if (dict_drop !== 1'b1) begin
            errors++;
            $display("FAIL t5_search_drop: got %b want 1", dict_drop);
        end
        while (!out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 8 || out_compressible !== 1'b0) begin
            errors++;
            $display("FAIL t5_search_result: lat=%0d comp=%b, want 8 0", lat, out_compressible);
        end
        pop();
        clear_dicts();
        checks++;
        if (dict_full !== 3'b000) begin
            errors++;
            $display("FAIL t5_clear: got %b want 000", dict_full);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        load_t3();
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = 32'h00100093;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (50) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || stat_total !== 32'h0 || stat_hits !== 32'h0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL t6_abort: valid=%b total=%0d hits=%0d ready=%b, want 0 0 0 0",
                     out_valid, stat_total, stat_hits, in_ready);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        run(32'h00100093, lat);
        checks++;
        if (lat != 256 || out_compressible !== 1'b0 || out_code !== 16'h0000) begin
            errors++;
            $display("FAIL t6_rerun: lat=%0d comp=%b code=%h, want 256 0 0000",
                     lat, out_compressible, out_code);
        end
        pop();
        checks++;
        if (stat_total !== 32'd1 || stat_hits !== 32'd0) begin
            errors++;
            $display("FAIL t6_stats: total=%0d hits=%0d, want 1 0", stat_total, stat_hits);
        end
        load_t1();
        run(32'h00100093, lat);
        checks++;
        if (lat != 1 || out_compressible !== 1'b1 || out_code !== 16'h0000) begin
            errors++;
            $display("FAIL t6_t1_after_reset: lat=%0d comp=%b code=%h, want 1 1 0000",
                     lat, out_compressible, out_code);
        end
        pop();
    endtask

    initial begin
        resetn = 1'b0;
        dict1_write_enable = 1'b0;
        dict2_write_enable = 1'b0;
        dict3_write_enable = 1'b0;
        dict1_write_val = '0;
        dict2_write_val = '0;
        dict3_write_val = '0;
        dict_clear = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        out_ready = 1'b0;
        test_reset();
        test_exact_hit_hold();
        test_offset_hit();
        test_full_miss();
        test_drop_and_clear();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
